uk_seq: RTL and testbench

- Nibble-code sequencer that fetches 4-bit program words from the 1024x4 keyboard/sound program PROM and interprets them.
- Drives the PROM address and consumes its registered nibble output.
- Emits a symbol stream (bit0 / bit1 / mark) to the downstream serializer over a valid/ready handshake.
- Also supports jumps, timed waits, a 4-bit output latch and program end.

---
 rtl/uk_seq_if.sv | 27 ++
 rtl/uk_seq.sv | 175 +++++++++++++++++
 tb/tb_uk_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uk_seq_if.sv
// PROM fetch port and symbol stream between the sequencer and its neighbours.
// The master side drives the PROM address and offers symbols. The slave side returns nibbles and sym_ready.
interface uk_seq_if #(
    parameter int ADR_W = 10
) ();
    logic [ADR_W-1:0] rom_adr;
    logic [3:0]       rom_data;
    logic             sym_valid;
    logic [1:0]       sym_data;
    logic             sym_ready;

    modport master (
        output rom_adr,
        input  rom_data,
        output sym_valid,
        output sym_data,
        input  sym_ready
    );

    modport slave (
        input  rom_adr,
        output rom_data,
        input  sym_valid,
        input  sym_data,
        output sym_ready
    );
endinterface

// File: rtl/uk_seq.sv
// Nibble-code sequencer: fetches PROM nibbles (2 cycles each) and emits bit0/bit1/mark symbols.
// Opcode capture to sym_valid takes 1 cycle; the symbol is held in EMIT until sym_ready, so the sequencer stalls.
module uk_seq #(
    parameter int DELAY_UNIT = 16,
    parameter int ADR_W      = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [ADR_W-1:0] start_adr,
    uk_seq_if.master         bus,
    output logic [3:0]       port_out,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_READ, S_OP_ISSUE, S_OP_READ, S_EMIT, S_DELAY
    } state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] pc_q, pc_d;
    logic [3:0]       opc_q, opc_d;
    logic [1:0]       opn_q, opn_d;
    logic [3:0]       opa_q, opa_d;
    logic [3:0]       opb_q, opb_d;
    logic             sym_valid_q, sym_valid_d;
    logic [1:0]       sym_data_q, sym_data_d;
    logic [3:0]       port_q, port_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Resolves false for X/Z nibbles in 4-state simulation and is constant-true in hardware,
    // so an undefined nibble can never be latched into state.
    logic             rd_known;
    logic [CNT_W-1:0] wait_cnt;

    assign rd_known = ((bus.rom_data ^ bus.rom_data) == 4'h0);
    assign wait_cnt = CNT_W'({opa_q, bus.rom_data}) * CNT_W'(DELAY_UNIT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opc_d       = opc_q;
        opn_d       = opn_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sym_valid_d = sym_valid_q;
        sym_data_d  = sym_data_q;
        port_d      = port_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                // done_q marks the cycle END retires; a start there is still treated as busy
                if (start && !done_q) begin
                    pc_d    = start_adr;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:    state_d = S_READ;
            S_READ: begin
                pc_d    = pc_q + ADR_W'(1);
                state_d = S_ISSUE;
                opn_d   = 2'd0;
                if (rd_known) begin
                    opc_d = bus.rom_data;
                    case (bus.rom_data)
                        4'h1, 4'h8, 4'hB: state_d = S_OP_ISSUE;
                        4'h4: begin sym_valid_d = 1'b1; sym_data_d = 2'd2; state_d = S_EMIT; end
                        4'h5: begin sym_valid_d = 1'b1; sym_data_d = 2'd0; state_d = S_EMIT; end
                        4'h6: begin sym_valid_d = 1'b1; sym_data_d = 2'd1; state_d = S_EMIT; end
                        4'hE: begin
                            pc_d    = pc_q;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            S_OP_ISSUE: state_d = S_OP_READ;
            S_OP_READ: begin
                pc_d    = pc_q + ADR_W'(1);
                opn_d   = opn_q + 2'd1;
                state_d = S_OP_ISSUE;
                if (!rd_known) begin
                    state_d = S_ISSUE;
                end else begin
                    case (opc_q)
                        4'h1: begin
                            if (opn_q == 2'd0) begin
                                opa_d = bus.rom_data;
                            end else if (opn_q == 2'd1) begin
                                opb_d = bus.rom_data;
                            end else begin
                                pc_d    = ADR_W'({opa_q[1:0], opb_q, bus.rom_data});
                                state_d = S_ISSUE;
                            end
                        end
                        4'h8: begin
                            if (opn_q == 2'd0) begin
                                opa_d = bus.rom_data;
                            end else begin
                                cnt_d   = wait_cnt;
                                state_d = (wait_cnt == '0) ? S_ISSUE : S_DELAY;
                            end
                        end
                        4'hB: begin
                            port_d  = bus.rom_data;
                            state_d = S_ISSUE;
                        end
                        default: state_d = S_ISSUE;
                    endcase
                end
            end
            S_EMIT: begin
                if (bus.sym_ready) begin
                    sym_valid_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_DELAY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            opc_q       <= 4'h0;
            opn_q       <= 2'd0;
            opa_q       <= 4'h0;
            opb_q       <= 4'h0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= 2'd0;
            port_q      <= 4'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opc_q       <= opc_d;
            opn_q       <= opn_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            port_q      <= port_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.rom_adr   = pc_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_data  = sym_data_q;
    assign port_out      = port_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_uk_seq.sv
// Directed bench for uk_seq: a registered PROM model and per-cycle recording, with inline checks in each test.
module tb_uk_seq;
    logic       clk;
    logic       reset_n;
    logic       start;
    logic [9:0] start_adr;
    logic [3:0] port_out;
    logic       busy;
    logic       done;

    uk_seq_if #(.ADR_W(10)) bus ();

    uk_seq #(.DELAY_UNIT(16), .ADR_W(10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .start_adr (start_adr),
        .bus       (bus),
        .port_out  (port_out),
        .busy      (busy),
        .done      (done)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] rom [0:1023];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_adr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle c (1-based) is the c-th cycle after the edge that samples start.
    logic       rec_v    [0:127];
    logic [1:0] rec_d    [0:127];
    logic       rec_done [0:127];
    logic       rec_busy [0:127];
    logic [9:0] rec_adr  [0:127];
    logic [3:0] rec_port [0:127];
    bit         rdy_sched[0:127];
    bit         st_sched [0:127];
    bit         xseen;

    task automatic clear_sched();
        for (int i = 0; i < 128; i++) begin
            rdy_sched[i] = 1'b1;
            st_sched[i]  = 1'b0;
        end
    endtask

    task automatic start_and_record(input logic [9:0] adr, input int n);
        start     = 1'b1;
        start_adr = adr;
        bus.sym_ready = 1'b1;
        xseen = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            start         = st_sched[c];
            start_adr     = st_sched[c] ? 10'h2AA : adr;
            bus.sym_ready = rdy_sched[c];
            rec_v[c]    = bus.sym_valid;
            rec_d[c]    = bus.sym_data;
            rec_done[c] = done;
            rec_busy[c] = busy;
            rec_adr[c]  = bus.rom_adr;
            rec_port[c] = port_out;
            if ($isunknown({bus.sym_valid, bus.sym_data, bus.rom_adr, port_out, busy, done}))
                xseen = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; start_adr = 10'h155; bus.sym_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.rom_adr !== 10'h000) begin errors++; $display("FAIL rst_rom_adr got=%h exp=000", bus.rom_adr); end
        checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL rst_sym_valid got=%b exp=0", bus.sym_valid); end
        checks++; if (bus.sym_data !== 2'd0) begin errors++; $display("FAIL rst_sym_data got=%0d exp=0", bus.sym_data); end
        checks++; if (port_out !== 4'h0) begin errors++; $display("FAIL rst_port_out got=%h exp=0", port_out); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done got=%b exp=00", {busy, done}); end
        reset_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
        start = 1'b1; start_adr = 10'h010;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
        checks++; if (bus.rom_adr !== 10'h010) begin errors++; $display("FAIL start_rom_adr got=%h exp=010", bus.rom_adr); end
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        int tc[$]; int td[$]; int nd; int nv;
        clear_sched();
        start_and_record(10'h010, 16);
        nd = 0; nv = 0;
        for (int c = 1; c <= 16; c++) begin
            if (rec_v[c]) nv++;
            if (rec_v[c] && rdy_sched[c]) begin tc.push_back(c); td.push_back(int'(rec_d[c])); end
            if (rec_done[c]) nd++;
        end
        checks++; if (tc.size() != 3 || nv != 3) begin errors++; $display("FAIL stream_count got=%0d/%0d exp=3/3", tc.size(), nv); end
        else begin
            checks++; if (tc[0] != 3 || tc[1] != 6 || tc[2] != 9) begin errors++; $display("FAIL stream_cycles got=%0d,%0d,%0d exp=3,6,9", tc[0], tc[1], tc[2]); end
            checks++; if (td[0] != 0 || td[1] != 1 || td[2] != 2) begin errors++; $display("FAIL stream_data got=%0d,%0d,%0d exp=0,1,2", td[0], td[1], td[2]); end
        end
        checks++; if (nd != 1 || rec_done[12] !== 1'b1) begin errors++; $display("FAIL stream_done got=%0d@12=%b exp=1@12=1", nd, rec_done[12]); end
        checks++; if ({rec_busy[11], rec_busy[12]} !== 2'b10) begin errors++; $display("FAIL stream_busy_fall got=%b exp=10", {rec_busy[11], rec_busy[12]}); end
    endtask

    task automatic test_backpressure();
        int tc[$]; int td[$]; int held;
        clear_sched();
        for (int c = 6; c <= 15; c++) rdy_sched[c] = 1'b0;
        start_and_record(10'h010, 26);
        held = 0;
        for (int c = 1; c <= 26; c++) begin
            if (rec_v[c] && rec_d[c] == 2'd1 && !rdy_sched[c]) held++;
            if (rec_v[c] && rdy_sched[c]) begin tc.push_back(c); td.push_back(int'(rec_d[c])); end
        end
        checks++; if (held != 10) begin errors++; $display("FAIL bp_held got=%0d exp=10", held); end
        checks++; if (tc.size() != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", tc.size()); end
        else begin
            checks++; if (tc[0] != 3 || tc[1] != 16 || tc[2] != 19) begin errors++; $display("FAIL bp_cycles got=%0d,%0d,%0d exp=3,16,19", tc[0], tc[1], tc[2]); end
            checks++; if (td[0] != 0 || td[1] != 1 || td[2] != 2) begin errors++; $display("FAIL bp_data got=%0d,%0d,%0d exp=0,1,2", td[0], td[1], td[2]); end
        end
        checks++; if (rec_done[22] !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", rec_done[22]); end
    endtask

    task automatic test_start_ignored();
        int nd; int bad;
        clear_sched();
        st_sched[4]  = 1'b1;
        st_sched[12] = 1'b1;
        start_and_record(10'h010, 16);
        nd = 0; bad = 0;
        for (int c = 1; c <= 16; c++) begin
            if (rec_done[c]) nd++;
            if (rec_adr[c] == 10'h2AA) bad++;
        end
        checks++; if (rec_v[9] !== 1'b1 || rec_d[9] !== 2'd2 || nd != 1) begin errors++; $display("FAIL ign_stream got=v%b d%0d done%0d exp=v1 d2 done1", rec_v[9], rec_d[9], nd); end
        checks++; if (bad != 0) begin errors++; $display("FAIL ign_adr got=%0d exp=0", bad); end
        checks++; if ({rec_busy[13], rec_busy[14], rec_busy[16]} !== 3'b000) begin errors++; $display("FAIL ign_busy got=%b exp=000", {rec_busy[13], rec_busy[14], rec_busy[16]}); end
    endtask

    task automatic test_jmp_wrap();
        clear_sched();
        start_and_record(10'h3FE, 18);
        checks++; if (rec_adr[1] !== 10'h3FE) begin errors++; $display("FAIL jmp_adr1 got=%h exp=3fe", rec_adr[1]); end
        checks++; if ({rec_adr[3], rec_adr[5], rec_adr[7]} !== {10'h3FF, 10'h000, 10'h001}) begin errors++; $display("FAIL jmp_opnd_adr got=%h,%h,%h exp=3ff,000,001", rec_adr[3], rec_adr[5], rec_adr[7]); end
        checks++; if (rec_adr[9] !== 10'h100) begin errors++; $display("FAIL jmp_target got=%h exp=100", rec_adr[9]); end
        checks++; if ({rec_port[12], rec_port[13]} !== 8'h0A) begin errors++; $display("FAIL setp_port got=%h,%h exp=0,a", rec_port[12], rec_port[13]); end
        checks++; if (rec_done[15] !== 1'b1 || rec_done[14] !== 1'b0) begin errors++; $display("FAIL jmp_done got=%b%b exp=01", rec_done[14], rec_done[15]); end
    endtask

    task automatic test_wait();
        int fv; int fd;
        clear_sched();
        start_and_record(10'h200, 64);
        fv = 0; fd = 0;
        for (int c = 64; c >= 1; c--) begin
            if (rec_v[c]) fv = c;
            if (rec_done[c]) fd = c;
        end
        checks++; if (fv != 57) begin errors++; $display("FAIL wait48_sym got=%0d exp=57", fv); end
        checks++; if (fd != 60) begin errors++; $display("FAIL wait48_done got=%0d exp=60", fd); end
        checks++; if (rec_busy[30] !== 1'b1 || rec_adr[30] !== 10'h203) begin errors++; $display("FAIL wait48_stall got=%b/%h exp=1/203", rec_busy[30], rec_adr[30]); end
        clear_sched();
        start_and_record(10'h240, 14);
        fv = 0; fd = 0;
        for (int c = 14; c >= 1; c--) begin
            if (rec_v[c]) fv = c;
            if (rec_done[c]) fd = c;
        end
        checks++; if (fv != 9 || fd != 12) begin errors++; $display("FAIL wait0 got=sym%0d done%0d exp=sym9 done12", fv, fd); end
    endtask

    task automatic test_x_nibble();
        int fv;
        clear_sched();
        start_and_record(10'h300, 12);
        fv = 0;
        for (int c = 12; c >= 1; c--) if (rec_v[c]) fv = c;
        checks++; if (xseen !== 1'b0) begin errors++; $display("FAIL x_outputs got=%b exp=0", xseen); end
        checks++; if (fv != 5 || rec_d[5] !== 2'd1) begin errors++; $display("FAIL x_nop got=sym%0d d%0d exp=sym5 d1", fv, rec_d[5]); end
        checks++; if (rec_done[8] !== 1'b1) begin errors++; $display("FAIL x_done got=%b exp=1", rec_done[8]); end
    endtask

    task automatic test_reset_mid();
        clear_sched();
        start_and_record(10'h200, 20);
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, bus.sym_valid, done} !== 3'b000) begin errors++; $display("FAIL rdelay_outs got=%b exp=000", {busy, bus.sym_valid, done}); end
        checks++; if (dut.cnt_q !== '0 || bus.rom_adr !== 10'h000) begin errors++; $display("FAIL rdelay_state got=cnt%0d adr%h exp=cnt0 adr000", dut.cnt_q, bus.rom_adr); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdelay_idle got=%b exp=0", busy); end
        clear_sched();
        for (int c = 1; c < 128; c++) rdy_sched[c] = 1'b0;
        start_and_record(10'h010, 5);
        checks++; if (rec_v[5] !== 1'b1) begin errors++; $display("FAIL remit_pre got=%b exp=1", rec_v[5]); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.sym_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL remit_drop got=%b%b exp=00", bus.sym_valid, busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.sym_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 4'h0;
        rom[10'h010] = 4'h5; rom[10'h011] = 4'h6; rom[10'h012] = 4'h4; rom[10'h013] = 4'hE;
        rom[10'h3FE] = 4'h1; rom[10'h3FF] = 4'h9; rom[10'h000] = 4'h0; rom[10'h001] = 4'h0;
        rom[10'h100] = 4'hB; rom[10'h101] = 4'hA; rom[10'h102] = 4'hE;
        rom[10'h200] = 4'h8; rom[10'h201] = 4'h0; rom[10'h202] = 4'h3; rom[10'h203] = 4'h6; rom[10'h204] = 4'hE;
        rom[10'h240] = 4'h8; rom[10'h241] = 4'h0; rom[10'h242] = 4'h0; rom[10'h243] = 4'h6; rom[10'h244] = 4'hE;
        rom[10'h300] = 4'bxxxx; rom[10'h301] = 4'h6; rom[10'h302] = 4'hE;
        reset_n = 1'b0; start = 1'b0; start_adr = 10'h000; bus.sym_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_start_ignored();
        test_jmp_wrap();
        test_wait();
        test_x_nibble();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
